r2sdf_stage: RTL and testbench

//  Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT pipeline.

---
 rtl/r2sdf_stage.sv | 145 ++++++++++++++
 tb/tb_r2sdf_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with internal control,
// valid-gated stalls, per-frame halving, flush of pending differences and frame resync.
module r2sdf_stage #(
    parameter int unsigned BW         = 22,
    parameter int unsigned LOG2_DEPTH = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          in_frame_start,
    input  logic [BW-1:0] in_real,
    input  logic [BW-1:0] in_imag,
    input  logic          scale,
    input  logic          flush,
    output logic          out_valid,
    output logic          out_frame_start,
    output logic [BW:0]   out_real,
    output logic [BW:0]   out_imag,
    output logic          sync_err
);

    localparam int D  = 2 ** LOG2_DEPTH;
    localparam int CW = LOG2_DEPTH + 1;
    localparam logic [CW-1:0] LastFill  = CW'(D - 1);
    localparam logic [CW-1:0] FirstBfly = CW'(D);

    // Stage A: registered inputs
    logic          a_valid_q, a_fs_q, a_flush_q, a_scale_q;
    logic [BW-1:0] a_re_q, a_im_q;

    // Stage B state
    logic [CW-1:0] cnt_q;
    logic          primed_q, scale_q, scale_m_q;
    logic [BW:0]   dl_re_q [D];
    logic [BW:0]   dl_im_q [D];

    logic          out_valid_q, out_fs_q, sync_err_q;
    logic [BW:0]   out_re_q, out_im_q;

    logic          resync, fill, flush_step, step, out_valid_d, out_fs_d, sel_scale;
    logic [CW-1:0] c_eff, cnt_d;
    logic [BW:0]   x_re, x_im, h_re, h_im, sum_re, sum_im, diff_re, diff_im;
    logic [BW:0]   push_re, push_im, res_re, res_im;

    function automatic logic [BW:0] halve(input logic [BW:0] v, input logic s);
        return s ? {v[BW], v[BW:1]} : v;
    endfunction

    always_comb begin
        resync      = a_valid_q & a_fs_q & (cnt_q != '0);
        c_eff       = resync ? '0 : cnt_q;
        fill        = ~c_eff[LOG2_DEPTH];
        flush_step  = a_flush_q & primed_q & fill;
        step        = a_valid_q | flush_step;
        // A flush step behaves as a zero-valued sample
        x_re        = a_valid_q ? {a_re_q[BW-1], a_re_q} : '0;
        x_im        = a_valid_q ? {a_im_q[BW-1], a_im_q} : '0;
        h_re        = dl_re_q[D-1];
        h_im        = dl_im_q[D-1];
        sum_re      = h_re + x_re;
        sum_im      = h_im + x_im;
        diff_re     = h_re - x_re;
        diff_im     = h_im - x_im;
        push_re     = fill ? x_re : diff_re;
        push_im     = fill ? x_im : diff_im;
        // Drained differences keep the scale of the frame that produced them
        sel_scale   = fill ? scale_m_q : scale_q;
        res_re      = halve(fill ? h_re : sum_re, sel_scale);
        res_im      = halve(fill ? h_im : sum_im, sel_scale);
        out_valid_d = step & (~fill | (primed_q & ~resync));
        out_fs_d    = step & ~fill & (c_eff == FirstBfly);
        cnt_d       = (flush_step && (c_eff == LastFill)) ? '0 : c_eff + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid_q <= 1'b0;
            a_fs_q    <= 1'b0;
            a_flush_q <= 1'b0;
            a_scale_q <= 1'b0;
            a_re_q    <= '0;
            a_im_q    <= '0;
        end else begin
            a_valid_q <= in_valid;
            a_fs_q    <= in_valid & in_frame_start;
            a_flush_q <= ~in_valid & flush;
            a_scale_q <= scale;
            if (in_valid) begin
                a_re_q <= in_real;
                a_im_q <= in_imag;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            scale_q     <= 1'b0;
            scale_m_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_fs_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            for (int i = 0; i < D; i++) begin
                dl_re_q[i] <= '0;
                dl_im_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_fs_q    <= out_fs_d;
            sync_err_q  <= resync;
            if (out_valid_d) begin
                out_re_q <= res_re;
                out_im_q <= res_im;
            end
            if (step) begin
                cnt_q      <= cnt_d;
                dl_re_q[0] <= push_re;
                dl_im_q[0] <= push_im;
                for (int i = 1; i < D; i++) begin
                    dl_re_q[i] <= dl_re_q[i-1];
                    dl_im_q[i] <= dl_im_q[i-1];
                end
                if (a_valid_q && (c_eff == '0)) begin
                    scale_q <= a_scale_q;
                end
                if (!fill) begin
                    primed_q  <= 1'b1;
                    scale_m_q <= scale_q;
                end else if (resync || (flush_step && (c_eff == LastFill))) begin
                    primed_q <= 1'b0;
                end
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_frame_start = out_fs_q;
    assign out_real        = out_re_q;
    assign out_imag        = out_im_q;
    assign sync_err        = sync_err_q;

endmodule

// File: tb/tb_r2sdf_stage.sv
// Scoreboard bench for r2sdf_stage: a frame-level reference model queues expected outputs
// (value, frame-start flag and arrival cycle); a negedge monitor pops and compares.
module tb_r2sdf_stage;

    localparam int BW = 8;
    localparam int L2 = 2;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_frame_start, scale, flush;
    logic [BW-1:0]   in_real, in_imag;
    logic            out_valid, out_frame_start, sync_err;
    logic [BW:0]     out_real, out_imag;

    r2sdf_stage #(.BW(BW), .LOG2_DEPTH(L2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_frame_start(in_frame_start),
        .in_real(in_real), .in_imag(in_imag), .scale(scale), .flush(flush),
        .out_valid(out_valid), .out_frame_start(out_frame_start),
        .out_real(out_real), .out_imag(out_imag), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; int re; int im; bit fs;} exp_t;
    exp_t sb[$];
    int   sync_q[$];
    int   obs[$];
    int   checks = 0, passes = 0, sync_seen = 0;

    // Reference model state: position in frame, first-half samples, pending differences
    int n = 0;
    int half_re[D], half_im[D];
    bit frame_scale = 1'b0;
    int pend_re[$], pend_im[$];
    int fr_re[8], fr_im[8];

    function automatic int halve(input int v, input bit s);
        return s ? (v >>> 1) : v;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic model_reset();
        n = 0;
        pend_re.delete(); pend_im.delete();
        sb.delete(); sync_q.delete();
    endtask

    task automatic model_accept(input int xr, input int xi, input bit fs, input bit sc);
        exp_t e;
        if (fs && n != 0) begin
            sync_q.push_back(cyc + 2);
            n = 0;
            pend_re.delete(); pend_im.delete();
        end
        if (n == 0) frame_scale = sc;
        e.cyc = cyc + 2;
        if (n < D) begin
            half_re[n] = xr;
            half_im[n] = xi;
            if (pend_re.size() > 0) begin
                e.re = pend_re.pop_front();
                e.im = pend_im.pop_front();
                e.fs = 1'b0;
                sb.push_back(e);
            end
        end else begin
            e.re = halve(half_re[n-D] + xr, frame_scale);
            e.im = halve(half_im[n-D] + xi, frame_scale);
            e.fs = (n == D);
            sb.push_back(e);
            pend_re.push_back(halve(half_re[n-D] - xr, frame_scale));
            pend_im.push_back(halve(half_im[n-D] - xi, frame_scale));
        end
        n = (n + 1) % (2 * D);
    endtask

    task automatic model_flush();
        exp_t e;
        if (pend_re.size() > 0 && n < D) begin
            half_re[n] = 0;
            half_im[n] = 0;
            e.cyc = cyc + 2;
            e.re  = pend_re.pop_front();
            e.im  = pend_im.pop_front();
            e.fs  = 1'b0;
            sb.push_back(e);
            n++;
            if (n == D) begin
                n = 0;
                pend_re.delete(); pend_im.delete();
            end
        end
    endtask

    task automatic drive(input bit v, input bit fs, input int xr, input int xi, input bit sc,
                         input bit fl);
        @(posedge clk);
        #1;
        in_valid       = v;
        in_frame_start = fs;
        in_real        = 8'(xr);
        in_imag        = 8'(xi);
        scale          = sc;
        flush          = fl;
        if (v) model_accept(xr, xi, fs, sc);
        else if (fl) model_flush();
    endtask

    task automatic idle(input int k);
        repeat (k) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_flush(input int k);
        repeat (k) drive(0, 0, 0, 0, 0, 1);
        idle(4);
    endtask

    task automatic send_frame(input bit sc, input bit gap);
        for (int k = 0; k < 8; k++) begin
            drive(1, k == 0, fr_re[k], fr_im[k], sc, 0);
            if (gap) drive(0, 0, 0, 0, sc, 0);
        end
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = k + 1;
            fr_im[k] = -3 * k;
        end
    endtask

    task automatic chk_obs(input string name, input int g0, input int g1, input int g2,
                           input int g3, input int g4, input int g5, input int g6, input int g7);
        int g[8];
        g = '{g0, g1, g2, g3, g4, g5, g6, g7};
        chk({name, " count"}, obs.size(), 8);
        for (int k = 0; k < 8 && k < obs.size(); k++) chk(name, obs[k], g[k]);
        obs.delete();
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, int'({out_valid, out_frame_start, sync_err, out_real, out_imag}), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result
    initial begin
        bit exp_s;
        forever begin
            @(negedge clk);
            if (!reset) begin
                while (sb.size() > 0 && sb[0].cyc < cyc) begin
                    checks++;
                    $display("FAIL missing output: required re=%0d at cycle %0d, out_valid low",
                             sb[0].re, sb[0].cyc);
                    void'(sb.pop_front());
                end
                if (out_valid) begin
                    obs.push_back(int'($signed(out_real)));
                    if (sb.size() == 0 || sb[0].cyc != cyc) begin
                        checks++;
                        $display("FAIL unexpected output: got re=%0d at cycle %0d, required none",
                                 $signed(out_real), cyc);
                    end else begin
                        chk("out_real", int'($signed(out_real)), sb[0].re);
                        chk("out_imag", int'($signed(out_imag)), sb[0].im);
                        chk("out_frame_start", int'(out_frame_start), int'(sb[0].fs));
                        void'(sb.pop_front());
                    end
                end
                exp_s = (sync_q.size() > 0 && sync_q[0] == cyc);
                if (exp_s) void'(sync_q.pop_front());
                if (sync_err) sync_seen++;
                if (sync_err || exp_s) chk("sync_err", int'(sync_err), int'(exp_s));
            end
        end
    end

    initial begin
        in_valid = 0; in_frame_start = 0; in_real = 0; in_imag = 0; scale = 0; flush = 0;
        reset = 1'b1;

        // Test 1: reset holds outputs at zero under random inputs
        repeat (5) begin
            @(posedge clk);
            #1;
            in_valid       = 1'($urandom);
            in_frame_start = 1'($urandom);
            in_real        = 8'($urandom);
            in_imag        = 8'($urandom);
            scale          = 1'($urandom);
            flush          = 1'($urandom);
            @(negedge clk);
            chk_reset_outputs("t1 reset outputs");
        end
        @(posedge clk);
        #1;
        in_valid = 0; in_frame_start = 0; flush = 0; scale = 0;
        reset = 1'b0;
        model_reset();
        idle(3);

        // Test 2: ramp frame, then drain
        obs.delete();
        load_ramp();
        send_frame(0, 0);
        do_flush(6);
        chk_obs("t2", 6, 8, 10, 12, -4, -4, -4, -4);

        // Test 3: halved outputs
        send_frame(1, 0);
        do_flush(6);
        chk_obs("t3", 3, 4, 5, 6, -2, -2, -2, -2);

        // Test 4: extremes that need the extra output bit
        fr_re = '{-128, 127, 0, 0, -128, -128, 0, 0};
        for (int k = 0; k < 8; k++) fr_im[k] = int'($urandom_range(0, 255)) - 128;
        send_frame(0, 0);
        do_flush(6);
        chk_obs("t4", -256, -1, 0, 0, 0, 255, 0, 0);

        // Test 5: bubble between every sample
        load_ramp();
        send_frame(0, 1);
        repeat (4) begin
            drive(0, 0, 0, 0, 0, 1);
            drive(0, 0, 0, 0, 0, 0);
        end
        idle(4);
        chk_obs("t5", 6, 8, 10, 12, -4, -4, -4, -4);

        // Test 6: frame start arriving at cnt=3
        sync_seen = 0;
        drive(1, 1, 50, 51, 0, 0);
        drive(1, 0, 52, 53, 0, 0);
        drive(1, 0, 54, 55, 0, 0);
        send_frame(0, 0);
        do_flush(6);
        chk("t6 sync pulses", sync_seen, 1);
        chk_obs("t6", 6, 8, 10, 12, -4, -4, -4, -4);

        // Test 7: reset mid-frame
        for (int k = 0; k < 5; k++) drive(1, k == 0, fr_re[k], fr_im[k], 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 0;
        model_reset();
        #1;
        chk_reset_outputs("t7 reset outputs");
        repeat (2) begin
            @(negedge clk);
            chk_reset_outputs("t7 reset held");
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        obs.delete();
        idle(2);
        send_frame(0, 0);
        do_flush(6);
        chk_obs("t7", 6, 8, 10, 12, -4, -4, -4, -4);

        // Random frames: random data, scale, bubbles, stray flushes and occasional resync
        for (int f = 0; f < 12; f++) begin
            int len;
            bit sc;
            sc  = 1'($urandom);
            len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
            for (int k = 0; k < len; k++) begin
                drive(1, k == 0, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 255)) - 128, sc, 0);
                if ($urandom_range(0, 3) == 0) drive(0, 0, 0, 0, sc, 1'($urandom));
            end
        end
        do_flush(6);
        idle(4);
        chk("scoreboard drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
